trans_issue_scheduler: RTL and testbench

//  Ingress scheduler in front of trans_validator. Buffers incoming 128-bit transactions
//  in a FIFO and issues them to the validator strictly one at a time, since the validator
//  is multi-cycle and exposes no ready. Waits for completion, counts accepted, rejected
//  and dropped transactions, and recovers from a hung validator via a timeout.

---
 rtl/trans_issue_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_trans_issue_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/trans_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : trans_issue_scheduler
//  Brief    : FIFO-buffered, one-at-a-time issue scheduler in front of the
//             multi-cycle transaction validator, with statistics and timeout.
//  Revision : 1.0
// ============================================================================
module trans_issue_scheduler #(
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 32,
    parameter int DONE_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [127:0]       data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [127:0]       val_data_o,
    output logic               val_valid_o,
    input  logic               val_accepted_i,
    input  logic               val_done_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   ok_cnt_o,
    output logic [CNT_W-1:0]   rej_cnt_o,
    output logic [CNT_W-1:0]   drop_cnt_o,
    output logic               overflow_o,
    output logic               timeout_o
);

    localparam int c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_TMO_W  = ($clog2(DONE_TIMEOUT + 1) < 1) ? 1 : $clog2(DONE_TIMEOUT + 1);

    localparam logic [c_ADDR_W:0]   c_FULL     = (c_ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0]   c_CNT_ONE  = (c_ADDR_W+1)'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);
    localparam logic [c_TMO_W-1:0]  c_TMO_MAX  = c_TMO_W'(DONE_TIMEOUT);
    localparam logic [c_TMO_W-1:0]  c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [CNT_W-1:0]    c_STAT_ONE = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd2;

    logic [127:0]        r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [c_ADDR_W:0]   w_count_nxt;
    logic                r_ready;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_acc;
    logic [c_TMO_W-1:0]  r_tmo;

    logic [127:0]        r_val_data;
    logic                r_val_valid;
    logic [CNT_W-1:0]    r_ok_cnt;
    logic [CNT_W-1:0]    r_rej_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic                r_overflow;
    logic                r_timeout;

    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_tmo_hit;
    logic w_ok_inc;
    logic w_rej_inc;
    logic w_tmo_abort;

    assign w_push    = valid_i && r_ready;
    assign w_drop    = valid_i && !r_ready;
    assign w_tmo_hit = (r_tmo == c_TMO_MAX);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:      if (r_count != '0) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE:     w_state_nxt = c_ST_WAIT_DONE;
            c_ST_WAIT_DONE: if (val_done_i || w_tmo_hit) w_state_nxt = c_ST_IDLE;
            default:        w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output / action decode
    always_comb begin
        w_pop       = 1'b0;
        w_ok_inc    = 1'b0;
        w_rej_inc   = 1'b0;
        w_tmo_abort = 1'b0;
        case (r_state)
            c_ST_ISSUE: w_pop = 1'b1;
            c_ST_WAIT_DONE: begin
                if (val_done_i) begin
                    w_ok_inc  = r_acc || val_accepted_i;
                    w_rej_inc = !(r_acc || val_accepted_i);
                end else if (w_tmo_hit) begin
                    w_rej_inc   = 1'b1;
                    w_tmo_abort = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ready     <= 1'b1;
            r_acc       <= 1'b0;
            r_tmo       <= '0;
            r_val_data  <= '0;
            r_val_valid <= 1'b0;
            r_ok_cnt    <= '0;
            r_rej_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_ready     <= (w_count_nxt != c_FULL);
            r_val_valid <= w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_val_data <= r_mem[r_rd_ptr];
                r_acc      <= 1'b0;
                r_tmo      <= '0;
            end else if (r_state == c_ST_WAIT_DONE) begin
                if (val_accepted_i) r_acc <= 1'b1;
                if (!val_done_i && !w_tmo_hit) r_tmo <= r_tmo + c_TMO_ONE;
            end
            // Statistics saturate rather than wrap
            if (w_ok_inc && (r_ok_cnt != '1))     r_ok_cnt   <= r_ok_cnt + c_STAT_ONE;
            if (w_rej_inc && (r_rej_cnt != '1))   r_rej_cnt  <= r_rej_cnt + c_STAT_ONE;
            if (w_drop && (r_drop_cnt != '1))     r_drop_cnt <= r_drop_cnt + c_STAT_ONE;
            if (w_drop)                           r_overflow <= 1'b1;
            if (w_tmo_abort)                      r_timeout  <= 1'b1;
        end
    end

    assign ready_o     = r_ready;
    assign val_data_o  = r_val_data;
    assign val_valid_o = r_val_valid;
    assign busy_o      = (r_state != c_ST_IDLE) || (r_count != '0);
    assign ok_cnt_o    = r_ok_cnt;
    assign rej_cnt_o   = r_rej_cnt;
    assign drop_cnt_o  = r_drop_cnt;
    assign overflow_o  = r_overflow;
    assign timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_trans_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trans_issue_scheduler
//  Brief    : Directed self-checking bench for trans_issue_scheduler.
//  Revision : 1.0
// ============================================================================
module tb_trans_issue_scheduler;

    localparam int c_DEPTH = 16;
    localparam int c_CW    = 32;
    localparam int c_TMO   = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [127:0]      data_i = '0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [127:0]      val_data_o;
    logic              val_valid_o;
    logic              val_accepted_i = 1'b0;
    logic              val_done_i = 1'b0;
    logic              busy_o;
    logic [c_CW-1:0]   ok_cnt_o;
    logic [c_CW-1:0]   rej_cnt_o;
    logic [c_CW-1:0]   drop_cnt_o;
    logic              overflow_o;
    logic              timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    trans_issue_scheduler #(
        .FIFO_DEPTH   (c_DEPTH),
        .CNT_W        (c_CW),
        .DONE_TIMEOUT (c_TMO)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .val_data_o     (val_data_o),
        .val_valid_o    (val_valid_o),
        .val_accepted_i (val_accepted_i),
        .val_done_i     (val_done_i),
        .busy_o         (busy_o),
        .ok_cnt_o       (ok_cnt_o),
        .rej_cnt_o      (rej_cnt_o),
        .drop_cnt_o     (drop_cnt_o),
        .overflow_o     (overflow_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [47:0] s, input logic [47:0] r,
                                        input logic [21:0] amt, input logic b);
        return {s, r, amt, b, 9'h000};
    endfunction

    task automatic push(input logic [127:0] d);
        data_i  = d;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"},    128'(ready_o),     128'd1);
        chk({tag, "_vvalid"},   128'(val_valid_o), 128'd0);
        chk({tag, "_vdata"},    val_data_o,        128'd0);
        chk({tag, "_busy"},     128'(busy_o),      128'd0);
        chk({tag, "_ok"},       128'(ok_cnt_o),    128'd0);
        chk({tag, "_rej"},      128'(rej_cnt_o),   128'd0);
        chk({tag, "_drop"},     128'(drop_cnt_o),  128'd0);
        chk({tag, "_overflow"}, 128'(overflow_o),  128'd0);
        chk({tag, "_timeout"},  128'(timeout_o),   128'd0);
    endtask

    // Validator model: wait for an issue, hold for lat cycles, then signal done.
    task automatic serve(input logic acc_same, input logic acc_early, input int lat,
                         output logic [127:0] d, output int wait_n);
        int extra;
        wait_n = 0;
        extra  = 0;
        while (!val_valid_o && wait_n < 60) begin
            tick();
            wait_n++;
        end
        if (!val_valid_o) chk("issue_wait_expired", 128'd0, 128'd1);
        d = val_data_o;
        tick();
        chk("pulse_one_cycle", 128'(val_valid_o), 128'd0);
        for (int i = 0; i < lat; i++) begin
            val_accepted_i = acc_early && (i == 0);
            tick();
            val_accepted_i = 1'b0;
            if (val_valid_o) extra++;
        end
        chk("no_overlap", 128'(extra), 128'd0);
        val_done_i     = 1'b1;
        val_accepted_i = acc_same;
        tick();
        val_done_i     = 1'b0;
        val_accepted_i = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] exp_q [3];
        int           n;

        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        // Single accepted transaction
        push(mk(48'hA1, 48'hB1, 22'd5, 1'b0));
        serve(1'b1, 1'b0, 9, d, n);
        chk("t1_data", d, mk(48'hA1, 48'hB1, 22'd5, 1'b0));
        chk("t1_ok",   128'(ok_cnt_o), 128'd1);
        chk("t1_busy", 128'(busy_o),   128'd0);

        // Three back-to-back, all rejected, strict order and spacing
        exp_q[0] = mk(48'h10, 48'h20, 22'd1, 1'b1);
        exp_q[1] = mk(48'h11, 48'h21, 22'd2, 1'b0);
        exp_q[2] = mk(48'h12, 48'h22, 22'd3, 1'b1);
        for (int i = 0; i < 3; i++) push(exp_q[i]);
        for (int i = 0; i < 3; i++) begin
            serve(1'b0, 1'b0, 4, d, n);
            chk("t2_order", d, exp_q[i]);
            if (i > 0) chk("t2_spacing", 128'(n), 128'd2);
        end
        chk("t2_rej", 128'(rej_cnt_o), 128'd3);
        chk("t2_ok",  128'(ok_cnt_o),  128'd1);

        // Accept with done in same cycle, then early accept, then done in IDLE
        push(mk(48'h30, 48'h40, 22'd7, 1'b0));
        serve(1'b1, 1'b0, 3, d, n);
        chk("t5_same_ok", 128'(ok_cnt_o), 128'd2);
        push(mk(48'h31, 48'h41, 22'd8, 1'b0));
        serve(1'b0, 1'b1, 3, d, n);
        chk("t5_early_ok", 128'(ok_cnt_o), 128'd3);
        val_done_i     = 1'b1;
        val_accepted_i = 1'b1;
        tick();
        tick();
        val_done_i     = 1'b0;
        val_accepted_i = 1'b0;
        chk("t5_idle_ok",  128'(ok_cnt_o),   128'd3);
        chk("t5_idle_rej", 128'(rej_cnt_o),  128'd3);
        chk("t5_idle_vv",  128'(val_valid_o), 128'd0);

        // Timeout: abort on the 21st WAIT_DONE cycle, then the next entry issues
        push(mk(48'h50, 48'h60, 22'd9, 1'b0));
        push(mk(48'h51, 48'h61, 22'd10, 1'b1));
        n = 0;
        while (!val_valid_o && n < 60) begin
            tick();
            n++;
        end
        chk("t4_first_data", val_data_o, mk(48'h50, 48'h60, 22'd9, 1'b0));
        repeat (20) tick();
        chk("t4_pre_tmo",  128'(timeout_o), 128'd0);
        chk("t4_pre_rej",  128'(rej_cnt_o), 128'd3);
        tick();
        chk("t4_tmo",      128'(timeout_o), 128'd1);
        chk("t4_rej",      128'(rej_cnt_o), 128'd4);
        serve(1'b1, 1'b0, 2, d, n);
        chk("t4_next_data", d, mk(48'h51, 48'h61, 22'd10, 1'b1));
        chk("t4_next_wait", 128'(n), 128'd2);
        chk("t4_ok",        128'(ok_cnt_o), 128'd4);

        // Overflow with a silent validator: one entry issues, 16 fill, the 18th drops
        for (int i = 0; i < 18; i++) begin
            push(mk(48'h700 + 48'(i), 48'h800, 22'(i), 1'b0));
            if (i == 15) chk("t3_ready_15", 128'(ready_o), 128'd1);
            if (i == 16) chk("t3_ready_16", 128'(ready_o), 128'd0);
        end
        chk("t3_drop",     128'(drop_cnt_o), 128'd1);
        chk("t3_overflow", 128'(overflow_o), 128'd1);
        chk("t3_ready",    128'(ready_o),    128'd0);
        chk("t3_issued",   val_data_o, mk(48'h700, 48'h800, 22'd0, 1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("t3_rst");

        // Reset mid-WAIT_DONE with 4 queued
        for (int i = 0; i < 5; i++) push(mk(48'h900 + 48'(i), 48'hA00, 22'(i + 1), 1'b0));
        chk("t6_busy",   128'(busy_o),  128'd1);
        chk("t6_issued", val_data_o, mk(48'h900, 48'hA00, 22'd1, 1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("t6_rst");
        push(mk(48'hC0, 48'hD0, 22'd33, 1'b1));
        serve(1'b1, 1'b0, 2, d, n);
        chk("t6_fresh_data", d, mk(48'hC0, 48'hD0, 22'd33, 1'b1));
        chk("t6_fresh_ok",   128'(ok_cnt_o), 128'd1);
        chk("t6_fresh_busy", 128'(busy_o),   128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
